fifo_wr_arb: RTL and testbench

- Two-requester round-robin write arbiter that shares the single write port of the synchronous 8-deep FIFO between two producers.
- Sequences each write as grant, transfer, then response.
- Routes the FIFO's wr_ack/wr_err handshake back to the requester that owns the write.
- Sits directly in front of the FIFO write interface. The read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_rr_pick.sv | 13 +
 rtl/fifo_wr_arb.sv | 106 ++++++++++
 tb/tb_fifo_wr_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write/read arbiters.
// State encodings are fixed; 2'b11 is unused and recovers to idle.
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_CNT_W     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT  = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Two-way round-robin picker, purely combinational (0 cycles).
// On a tie the requester that did not go last wins; no backpressure of its own.
module fifo_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;
  assign idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter for the FIFO write port: grant, transfer, response (3 cycles/write).
// `define FIFO_WR_ARB_FULL_BLOCK_EN to hold requesters off (no grant) while the FIFO is full.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  err0,
  output logic                  ack1,
  output logic                  err1,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  input  logic                  fifo_full,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_wr_err
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       last, last_nxt;
  logic       pick_vld, pick_idx;
  logic       req_own;
  logic       start_ok;

  fifo_rr_pick u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign req_own = owner ? req1 : req0;

`ifdef FIFO_WR_ARB_FULL_BLOCK_EN
  assign start_ok = pick_vld & ~fifo_full;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign start_ok         = pick_vld;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    ack0       = 1'b0;
    err0       = 1'b0;
    ack1       = 1'b0;
    err1       = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    case (state)
      ARB_IDLE: begin
        if (start_ok) begin
          state_nxt = ARB_GNT;
          owner_nxt = pick_idx;
        end
      end
      ARB_GNT: begin
        gnt0       = ~owner;
        gnt1       = owner;
        fifo_wr_en = req_own;
        fifo_din   = owner ? din1 : din0;
        if (req_own) begin
          state_nxt = ARB_RESP;
          last_nxt  = owner;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        // A missing ack counts as an error; ack is masked so ack/err never coincide.
        ack0      = ~owner & fifo_wr_ack & ~fifo_wr_err;
        err0      = ~owner & (fifo_wr_err | ~fifo_wr_ack);
        ack1      = owner & fifo_wr_ack & ~fifo_wr_err;
        err1      = owner & (fifo_wr_err | ~fifo_wr_ack);
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a behavioural 8-deep FIFO write-side model.
module tb_fifo_wr_arb;
  import fifo_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] din0, din1;
  logic        gnt0, gnt1, ack0, err0, ack1, err1;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        fifo_full, fifo_wr_ack, fifo_wr_err;

  logic        drop_ack;
  logic        rd_pop;
  int          cnt;
  logic [31:0] wr_log[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .din0        (din0),
    .req1        (req1),
    .din1        (din1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .ack0        (ack0),
    .err0        (err0),
    .ack1        (ack1),
    .err1        (err1),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .fifo_full   (fifo_full),
    .fifo_wr_ack (fifo_wr_ack),
    .fifo_wr_err (fifo_wr_err)
  );

  // FIFO write side: ack/err one cycle after wr_en is sampled.
  assign fifo_full = (cnt == FIFO_DEPTH);

  always @(posedge clk) begin
    if (reset) begin
      cnt         <= 0;
      fifo_wr_ack <= 1'b0;
      fifo_wr_err <= 1'b0;
      wr_log.delete();
    end else begin
      fifo_wr_ack <= 1'b0;
      fifo_wr_err <= 1'b0;
      if (fifo_wr_en) begin
        if (cnt < FIFO_DEPTH) begin
          fifo_wr_ack <= ~drop_ack;
          wr_log.push_back(fifo_din);
        end else begin
          fifo_wr_err <= ~drop_ack;
        end
      end
      cnt <= cnt + (((fifo_wr_en == 1'b1) && (cnt < FIFO_DEPTH)) ? 1 : 0)
                 - (((rd_pop == 1'b1) && (cnt > 0)) ? 1 : 0);
    end
  end

  function automatic logic [6:0] outs();
    return {gnt0, gnt1, ack0, err0, ack1, err1, fifo_wr_en};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    din0     = '0;
    din1     = '0;
    drop_ack = 1'b0;
    rd_pop   = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_outs", 64'(outs()), 64'h0);
    check("rst_din", 64'(fifo_din), 64'h0);

    // Single write from requester 0
    tick();
    reset = 1'b0;
    req0  = 1'b1;
    din0  = 32'hA5A5_0001;
    @(negedge clk);
    check("t1_idle", 64'(outs()), 64'h0);
    tick();
    @(negedge clk);
    check("t1_gnt", 64'(outs()), 64'(7'b1000001));
    check("t1_din", 64'(fifo_din), 64'hA5A5_0001);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("t1_ack", 64'(outs()), 64'(7'b0010000));
    tick();
    @(negedge clk);
    check("t1_back_idle", 64'(outs()), 64'h0);

    // Both requesting: alternate 0,1,0,1 and fill the FIFO
    tick();
    do_reset();
    din0 = 32'h0A00_0000;
    din1 = 32'h0B00_0000;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_idle", 64'(outs()), 64'h0);
      tick();
      @(negedge clk);
      check("rr_gnt", 64'({gnt0, gnt1}), (i % 2 == 1) ? 64'h1 : 64'h2);
      check("rr_din", 64'(fifo_din),
            (i % 2 == 1) ? 64'(32'h0B00_0000 + i / 2) : 64'(32'h0A00_0000 + i / 2));
      tick();
      if (i % 2 == 1) din1 = 32'h0B00_0000 + i / 2 + 1;
      else            din0 = 32'h0A00_0000 + i / 2 + 1;
      @(negedge clk);
      check("rr_ack", 64'({ack0, ack1, err0, err1}), (i % 2 == 1) ? 64'h4 : 64'h8);
      tick();
    end
    check("log_size", 64'(wr_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < wr_log.size())
        check("log_order", 64'(wr_log[k]),
              (k % 2 == 1) ? 64'(32'h0B00_0000 + k / 2) : 64'(32'h0A00_0000 + k / 2));
    end

    // FIFO full, requester 1 alone
    req0 = 1'b0;
`ifndef FIFO_WR_ARB_FULL_BLOCK_EN
    @(negedge clk);
    check("full_idle", 64'(outs()), 64'h0);
    tick();
    @(negedge clk);
    check("full_gnt", 64'(outs()), 64'(7'b0100001));
    tick();
    req1 = 1'b0;
    @(negedge clk);
    check("full_err", 64'(outs()), 64'(7'b0000010));
    tick();
    @(negedge clk);
    check("full_done", 64'(outs()), 64'h0);
`else
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check("blk_nogrant", 64'(outs()), 64'h0);
      tick();
    end
    rd_pop = 1'b1;
    @(negedge clk);
    check("blk_pop_cyc", 64'(outs()), 64'h0);
    tick();
    rd_pop = 1'b0;
    @(negedge clk);
    check("blk_not_full", 64'(fifo_full), 64'h0);
    check("blk_still_idle", 64'(outs()), 64'h0);
    tick();
    @(negedge clk);
    check("blk_gnt", 64'(outs()), 64'(7'b0100001));
    tick();
    req1 = 1'b0;
    @(negedge clk);
    check("blk_ack", 64'(outs()), 64'(7'b0000100));
`endif

    // Withdrawal in GNT leaves last unchanged
    tick();
    do_reset();
    req0 = 1'b1;
    din0 = 32'h0C0C_0001;
    @(negedge clk);
    check("wd_idle0", 64'(outs()), 64'h0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("wd_gnt_noen", 64'(outs()), 64'(7'b1000000));
    tick();
    @(negedge clk);
    check("wd_no_resp", 64'(outs()), 64'h0);
    tick();
    req0 = 1'b1;
    req1 = 1'b1;
    din1 = 32'h0D0D_0001;
    @(negedge clk);
    check("wd_idle1", 64'(outs()), 64'h0);
    tick();
    @(negedge clk);
    check("wd_last_kept", 64'(outs()), 64'(7'b1000001));
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("wd_ack0", 64'(outs()), 64'(7'b0010000));
    tick();
    @(negedge clk);
    check("wd_idle2", 64'(outs()), 64'h0);
    tick();
    @(negedge clk);
    check("wd_gnt1", 64'(outs()), 64'(7'b0100001));
    check("wd_din1", 64'(fifo_din), 64'h0D0D_0001);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    check("wd_ack1", 64'(outs()), 64'(7'b0000100));

    // Reset asserted during GNT
    tick();
    do_reset();
    req0 = 1'b1;
    din0 = 32'h0E0E_0001;
    tick();
    @(negedge clk);
    check("rm_gnt", 64'(outs()), 64'(7'b1000001));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0  = 1'b0;
    @(negedge clk);
    check("rm_idle", 64'(outs()), 64'h0);
    check("rm_din", 64'(fifo_din), 64'h0);
    tick();
    @(negedge clk);
    check("rm_no_resp", 64'(outs()), 64'h0);

    // Missing FIFO ack reported as error
    tick();
    req0 = 1'b1;
    din0 = 32'h0F0F_0001;
    tick();
    drop_ack = 1'b1;
    @(negedge clk);
    check("na_gnt", 64'(outs()), 64'(7'b1000001));
    tick();
    req0     = 1'b0;
    drop_ack = 1'b0;
    @(negedge clk);
    check("na_err0", 64'(outs()), 64'(7'b0001000));
    tick();
    @(negedge clk);
    check("na_idle", 64'(outs()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
